fft_sample_sequencer: RTL and testbench

FFT_SAMPLE_SEQUENCER -- requirements
Module: fft_sample_sequencer

---
 rtl/fft_sample_sequencer.sv | 139 +++++++++++++
 tb/tb_fft_sample_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_sequencer.sv
// Streams one N-sample frame from a 1-cycle-latency sample ROM to a valid/ready sink.
// Optional macro FFT_BIT_REVERSE_EN adds the bitrev input for bit-reversed read order.
module fft_sample_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_N     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
`ifdef FFT_BIT_REVERSE_EN
    input  logic                  bitrev,
`endif
    output logic [LOG2_N-1:0]     rom_addr,
    output logic                  rom_rd,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] IDX_ONE  = {{(LOG2_N-1){1'b0}}, 1'b1};

    state_t                state;
    logic [LOG2_N-1:0]     index;
    logic                  rev_q;
    logic                  frame_rev;
    logic                  rd_pend;
    logic                  pend_last;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  wptr;
    logic                  rptr;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  pop;
    logic                  last_pop;

    function automatic logic [LOG2_N-1:0] reverse_bits(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) r[i] = v[LOG2_N-1-i];
        return r;
    endfunction

`ifdef FFT_BIT_REVERSE_EN
    assign frame_rev = bitrev;
`else
    assign frame_rev = 1'b0;
`endif

    // Handshake: a sample transfers on a rising edge where out_valid=1 and out_ready=1;
    // while out_valid=1 and out_ready=0 the head entry (out_data/out_last) is held.
    // A read is issued only if the buffer, after this cycle's capture and pop, still
    // has room for it, so buffered plus in-flight samples never exceed two.
    always_comb begin
        out_valid = (occ != 2'd0);
        out_data  = buf_data[rptr];
        out_last  = out_valid & buf_last[rptr];
        pop       = out_valid & out_ready;
        last_pop  = pop & out_last;
        occ_next  = occ + {1'b0, rd_pend} - {1'b0, pop};
        rom_rd    = (state == RUN) && (occ_next < 2'd2);
        rom_addr  = rev_q ? reverse_bits(index) : index;
        busy      = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            index       <= '0;
            rev_q       <= 1'b0;
            rd_pend     <= 1'b0;
            pend_last   <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            occ         <= 2'd0;
            done        <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            // rom_q belongs to the read issued one cycle earlier; tag the frame's final read.
            rd_pend   <= rom_rd;
            pend_last <= rom_rd && (index == LAST_IDX);
            if (rd_pend) begin
                buf_data[wptr] <= rom_q;
                buf_last[wptr] <= pend_last;
                wptr           <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            occ  <= occ_next;
            done <= last_pop;
            if (last_pop) frame_cnt <= frame_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        index <= '0;
                        rev_q <= frame_rev;
                    end
                end
                RUN: begin
                    if (rom_rd) begin
                        index <= index + IDX_ONE;
                        if (index == LAST_IDX) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        if (continuous) begin
                            state <= RUN;
                            index <= '0;
                            rev_q <= frame_rev;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sample_sequencer.sv
// Scoreboard bench for fft_sample_sequencer (N=8): frame model pushes expected samples,
// a negedge monitor pops and compares on every accepted sample.
module tb_fft_sample_sequencer;

    localparam int DW = 32;
    localparam int LG = 3;
    localparam int N  = 1 << LG;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          continuous;
    logic          bitrev;
    logic [LG-1:0] rom_addr;
    logic          rom_rd;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [15:0]   frame_cnt;
    logic [1:0]    state_dbg;

    logic [DW-1:0] mem [N];
    logic [DW:0]   exp_q [$];

    int checks = 0;
    int failures = 0;
    bit mon_en = 0;
    bit rnd_ready = 0;
    bit done_exp = 0;
    int fc_exp = 0;
    int rd_issued = 0;
    int acc_cnt = 0;
    bit stall_prev = 0;
    logic [DW-1:0] held_data;
    logic held_last;

    fft_sample_sequencer #(.DATA_WIDTH(DW), .LOG2_N(LG)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
`ifdef FFT_BIT_REVERSE_EN
        .bitrev     (bitrev),
`endif
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_q      (rom_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt),
        .state_dbg  (state_dbg)
    );

    // clock / sample memory
    always #5 clk = ~clk;

    initial rom_q = '0;
    always @(posedge clk) if (rom_rd) rom_q <= mem[rom_addr];

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: frame k-th sample is mem at k (or k with its bits mirrored)
    function automatic int rev_idx(input int k);
        int r = 0;
        for (int b = 0; b < LG; b++) if ((k >> b) & 1) r = r | (1 << (LG - 1 - b));
        return r;
    endfunction

    task automatic push_frame(input bit rev);
        for (int k = 0; k < N; k++) begin
            int a;
            a = rev ? rev_idx(k) : k;
            exp_q.push_back({(k == N - 1), mem[a]});
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        done_exp = 0;
        fc_exp = 0;
        rd_issued = 0;
        acc_cnt = 0;
        stall_prev = 0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            bit hs;
            logic [DW:0] e;
            check("done", done, done_exp);
            if (done_exp) fc_exp++;
            check("frame_cnt", frame_cnt, fc_exp);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            hs = out_valid && out_ready;
            if (rom_rd) begin
                check("rd_room", ((rd_issued - acc_cnt - int'(hs)) < 2), 1);
                rd_issued++;
            end
            done_exp = 0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", out_data, 0);
                    checks++;
                    failures++;
                    $display("FAIL extra_sample actual=%0h expected=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[DW-1:0]);
                    check("out_last", out_last, e[DW]);
                    done_exp = e[DW];
                end
                acc_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
        end
    end

    // driver tasks
    task automatic check_reset_vals();
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_state", state_dbg, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 0;
        clear_model();
        #1 check_reset_vals();
        release_reset();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("drain_in_budget", (c < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
    endtask

    initial begin
        int c;
        int fv;
        bit drop;
        bit saw_v;
        reset = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        out_ready = 1'b0;
        bitrev = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;

        // basic frame, rom_q = addr*3, full throughput
        apply_reset();
        for (int i = 0; i < N; i++) mem[i] = i * 3;
        out_ready = 1'b1;
        push_frame(0);
        pulse_start();
        c = 0;
        fv = -1;
        forever begin
            @(negedge clk);
            if (!busy || c > 100) break;
            if (out_valid && fv < 0) fv = c;
            c++;
        end
        check("first_valid_latency", fv, 2);
        check("frame_cycles", c, N + 2);
        repeat (3) @(negedge clk);
        check("frame1_cnt", frame_cnt, 1);
        check("frame1_queue_empty", exp_q.size(), 0);

        // random backpressure, 8 frames = 64 samples
        apply_reset();
        for (int f = 0; f < 8; f++) begin
            fill_random();
            push_frame(0);
            rnd_ready = 1;
            pulse_start();
            wait_idle(400);
        end
        rnd_ready = 0;
        #2 out_ready = 1'b1;
        check("bp_accepted", acc_cnt, 64);
        check("bp_frame_cnt", frame_cnt, 8);

        // continuous mode, 3 frames
        apply_reset();
        fill_random();
        out_ready = 1'b1;
        continuous = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(0);
        pulse_start();
        c = 0;
        drop = 0;
        while (frame_cnt != 16'd3 && c < 200) begin
            @(negedge clk);
            c++;
            if (frame_cnt == 16'd2) continuous = 1'b0;
            if (!busy && frame_cnt < 16'd3) drop = 1;
        end
        check("cont_busy_held", drop, 0);
        check("cont_frame_cnt", frame_cnt, 3);
        repeat (2) @(negedge clk);
        check("cont_accepted", acc_cnt, 24);
        check("cont_idle", busy, 0);

        // reset asserted mid-frame after 5 samples
        apply_reset();
        fill_random();
        out_ready = 1'b1;
        push_frame(0);
        pulse_start();
        c = 0;
        while (acc_cnt < 5 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("mid_reached_5", (acc_cnt >= 5), 1);
        reset = 1'b0;
        mon_en = 0;
        #1 check_reset_vals();
        clear_model();
        release_reset();
        saw_v = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) saw_v = 1;
        end
        check("post_reset_quiet", saw_v, 0);
        fill_random();
        push_frame(0);
        pulse_start();
        wait_idle(100);
        check("post_reset_frame", frame_cnt, 1);

        // start held through the frame and during the final accept
        apply_reset();
        fill_random();
        out_ready = 1'b1;
        push_frame(0);
        @(posedge clk);
        #1 start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(out_valid && out_last) && c < 100);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("held_start_idle", busy, 0);
        check("held_start_cnt", frame_cnt, 1);
        check("held_start_queue", exp_q.size(), 0);

`ifdef FFT_BIT_REVERSE_EN
        // bit-reversed order, rom_q = addr
        apply_reset();
        for (int i = 0; i < N; i++) mem[i] = i;
        bitrev = 1'b1;
        push_frame(1);
        pulse_start();
        bitrev = 1'b0;
        wait_idle(100);
        check("bitrev_cnt", frame_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
